// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and forwarding helper for the FP-aware hazard unit
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int SRC_A = 0;
    localparam int SRC_B = 1;
    localparam int SRC_C = 2;
    localparam int NSRC  = 3;

    // Integer x0 never forwards; FP f0 is a real register and does.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             is_fp,
        input logic [REG_W-1:0] rd_m,
        input logic             we_m,
        input logic             fwe_m,
        input logic [REG_W-1:0] rd_w,
        input logic             we_w,
        input logic             fwe_w
    );
        logic nz;
        logic m_hit;
        logic w_hit;
        nz    = is_fp | (rs != '0);
        m_hit = nz & (rs == rd_m) & (is_fp ? fwe_m : we_m);
        w_hit = nz & (rs == rd_w) & (is_fp ? fwe_w : we_w);
        if (m_hit) begin
            return FWD_MEM;
        end else if (w_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - per-FP-register countdown scoreboard for in-flight FPU results
module fp_scoreboard
    import hazard_pkg::*;
#(
    parameter int NFREG   = 32,
    parameter int FPU_LAT = 4,
    parameter int CNT_W   = $clog2(FPU_LAT + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_i,
    input  logic [REG_W-1:0]           issue_rd_i,
    input  logic [NSRC-1:0][REG_W-1:0] src_idx_i,
    input  logic [REG_W-1:0]           dst_idx_i,
    output logic [NSRC-1:0]            src_busy_o,
    output logic                       dst_busy_o,
    output logic                       fpu_busy_o
);

    logic [NFREG-1:0][CNT_W-1:0] cnt_q;
    logic [NFREG-1:0][CNT_W-1:0] cnt_d;
    logic [NFREG-1:0]            nz;

    // Load the issuing destination with the full latency; all others count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NFREG; r++) begin
            if (issue_i && (issue_rd_i == REG_W'(r))) begin
                cnt_d[r] = CNT_W'(FPU_LAT);
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Counter array; reset clears every pending result, even mid-operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy lookups for the three Decode sources and the destination, plus global busy.
    always_comb begin
        nz         = '0;
        src_busy_o = '0;
        dst_busy_o = 1'b0;
        for (int r = 0; r < NFREG; r++) begin
            nz[r] = (cnt_q[r] != '0);
        end
        for (int r = 0; r < NFREG; r++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (src_idx_i[s] == REG_W'(r)) begin
                    src_busy_o[s] = src_busy_o[s] | nz[r];
                end
            end
            if (dst_idx_i == REG_W'(r)) begin
                dst_busy_o = dst_busy_o | nz[r];
            end
        end
        fpu_busy_o = |nz;
    end

endmodule

// File: rtl/fp_scoreboard_hazard_unit.sv
// rtl/fp_scoreboard_hazard_unit.sv - forwarding, load-use, FP scoreboard stall and flush control
module fp_scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NFREG         = 32,
    parameter int FPU_LAT       = 4,
    parameter int FPU_PIPELINED = 1,
    parameter int CNT_W         = $clog2(FPU_LAT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs3D,
    input  logic [REG_W-1:0] RdD,
    input  logic [2:0]       FpSrcD,
    input  logic             FpDstD,
    input  logic             FpuOpD,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] Rs3E,
    input  logic [REG_W-1:0] RdE,
    input  logic [2:0]       FpSrcE,
    input  logic             FpDstE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [REG_W-1:0] RdM,
    input  logic             RegWriteM,
    input  logic             FRegWriteM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteW,
    input  logic             FRegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [1:0]       ForwardCE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             lwStall,
    output logic             fpStall,
    output logic             FpuBusy
);

    logic [NSRC-1:0][REG_W-1:0] src_d;
    logic [NSRC-1:0]            src_busy;
    logic                       dst_busy;
    logic                       issue;
    logic                       fpu_serial;
    logic                       unused_result_src_hi;

    assign src_d[SRC_A]         = Rs1D;
    assign src_d[SRC_B]         = Rs2D;
    assign src_d[SRC_C]         = Rs3D;
    assign fpu_serial           = (FPU_PIPELINED == 0);
    assign unused_result_src_hi = ResultSrcE[1];

    // EX-stage operand forwarding, class-aware, Memory ahead of Writeback.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, FpSrcE[SRC_A], RdM, RegWriteM, FRegWriteM, RdW, RegWriteW, FRegWriteW);
        ForwardBE = fwd_sel(Rs2E, FpSrcE[SRC_B], RdM, RegWriteM, FRegWriteM, RdW, RegWriteW, FRegWriteW);
        ForwardCE = fwd_sel(Rs3E, FpSrcE[SRC_C], RdM, RegWriteM, FRegWriteM, RdW, RegWriteW, FRegWriteW);
    end

    // Load-use: a load in EX feeds a same-class Decode source; Rs3 only counts when it is an FP operand.
    always_comb begin
        logic [NSRC-1:0] hit;
        logic            rd_ok;
        rd_ok = FpDstE | (RdE != '0);
        hit   = '0;
        for (int s = 0; s < NSRC; s++) begin
            hit[s] = (src_d[s] == RdE) & (FpSrcD[s] == FpDstE) & rd_ok;
        end
        hit[SRC_C] = hit[SRC_C] & FpSrcD[SRC_C];
        lwStall    = ResultSrcE[0] & (|hit);
    end

    // Scoreboard stall (RAW, WAW, serial-FPU structural) and the combined pipeline controls.
    always_comb begin
        fpStall = (|(FpSrcD & src_busy))
                | (FpDstD & dst_busy)
                | (FpuOpD & fpu_serial & FpuBusy);
        StallF  = lwStall | fpStall;
        StallD  = lwStall | fpStall;
        FlushD  = PCSrcE;
        FlushE  = lwStall | fpStall | PCSrcE;
        issue   = FpuOpD & ~StallD & ~FlushD;
    end

    fp_scoreboard #(
        .NFREG   (NFREG),
        .FPU_LAT (FPU_LAT),
        .CNT_W   (CNT_W)
    ) u_fp_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_i    (issue),
        .issue_rd_i (RdD),
        .src_idx_i  (src_d),
        .dst_idx_i  (RdD),
        .src_busy_o (src_busy),
        .dst_busy_o (dst_busy),
        .fpu_busy_o (FpuBusy)
    );

endmodule

// File: tb/tb_fp_scoreboard_hazard_unit.sv
// tb/tb_fp_scoreboard_hazard_unit.sv - scoreboard bench for pipelined and serial FPU hazard units
module tb_fp_scoreboard_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs3D, RdD;
    logic [2:0] FpSrcD;
    logic       FpDstD, FpuOpD;
    logic [4:0] Rs1E, Rs2E, Rs3E, RdE;
    logic [2:0] FpSrcE;
    logic       FpDstE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic [4:0] RdM, RdW;
    logic       RegWriteM, FRegWriteM, RegWriteW, FRegWriteW;

    logic [1:0] fa_p, fb_p, fc_p, fa_n, fb_n, fc_n;
    logic       stallf_p, stalld_p, flushd_p, flushe_p, lw_p, fp_p, busy_p;
    logic       stallf_n, stalld_n, flushd_n, flushe_n, lw_n, fp_n, busy_n;

    always #5 clk = ~clk;

    fp_scoreboard_hazard_unit #(.NFREG(32), .FPU_LAT(4), .FPU_PIPELINED(1)) dut_p (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D), .RdD(RdD),
        .FpSrcD(FpSrcD), .FpDstD(FpDstD), .FpuOpD(FpuOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs3E(Rs3E), .RdE(RdE),
        .FpSrcE(FpSrcE), .FpDstE(FpDstE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .FRegWriteM(FRegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .FRegWriteW(FRegWriteW),
        .ForwardAE(fa_p), .ForwardBE(fb_p), .ForwardCE(fc_p),
        .StallF(stallf_p), .StallD(stalld_p), .FlushD(flushd_p), .FlushE(flushe_p),
        .lwStall(lw_p), .fpStall(fp_p), .FpuBusy(busy_p)
    );

    fp_scoreboard_hazard_unit #(.NFREG(32), .FPU_LAT(4), .FPU_PIPELINED(0)) dut_n (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D), .RdD(RdD),
        .FpSrcD(FpSrcD), .FpDstD(FpDstD), .FpuOpD(FpuOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs3E(Rs3E), .RdE(RdE),
        .FpSrcE(FpSrcE), .FpDstE(FpDstE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .FRegWriteM(FRegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .FRegWriteW(FRegWriteW),
        .ForwardAE(fa_n), .ForwardBE(fb_n), .ForwardCE(fc_n),
        .StallF(stallf_n), .StallD(stalld_n), .FlushD(flushd_n), .FlushE(flushe_n),
        .lwStall(lw_n), .fpStall(fp_n), .FpuBusy(busy_n)
    );

    typedef struct {
        string      tag;
        logic [1:0] fa, fb, fc;
        logic       lw, fp, busy, fpn, busyn, flushd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, want);
        end
    endtask

    // Monitor: whenever a vector is pending, compare both instances mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic st_p, st_n;
            e    = exp_q.pop_front();
            st_p = e.lw | e.fp;
            st_n = e.lw | e.fpn;
            cmp({e.tag, " ForwardAE"}, fa_p, e.fa);
            cmp({e.tag, " ForwardBE"}, fb_p, e.fb);
            cmp({e.tag, " ForwardCE"}, fc_p, e.fc);
            cmp({e.tag, " lwStall"},   {1'b0, lw_p},     {1'b0, e.lw});
            cmp({e.tag, " fpStall"},   {1'b0, fp_p},     {1'b0, e.fp});
            cmp({e.tag, " FpuBusy"},   {1'b0, busy_p},   {1'b0, e.busy});
            cmp({e.tag, " StallF"},    {1'b0, stallf_p}, {1'b0, st_p});
            cmp({e.tag, " StallD"},    {1'b0, stalld_p}, {1'b0, st_p});
            cmp({e.tag, " FlushD"},    {1'b0, flushd_p}, {1'b0, e.flushd});
            cmp({e.tag, " FlushE"},    {1'b0, flushe_p}, {1'b0, st_p | e.flushd});
            cmp({e.tag, " np fpStall"}, {1'b0, fp_n},     {1'b0, e.fpn});
            cmp({e.tag, " np FpuBusy"}, {1'b0, busy_n},   {1'b0, e.busyn});
            cmp({e.tag, " np StallD"},  {1'b0, stalld_n}, {1'b0, st_n});
            cmp({e.tag, " np FlushE"},  {1'b0, flushe_n}, {1'b0, st_n | e.flushd});
        end
    end

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs3D = '0; RdD = '0;
        FpSrcD = '0; FpDstD = 1'b0; FpuOpD = 1'b0;
        Rs1E = '0; Rs2E = '0; Rs3E = '0; RdE = '0;
        FpSrcE = '0; FpDstE = 1'b0; ResultSrcE = '0; PCSrcE = 1'b0;
        RdM = '0; RegWriteM = 1'b0; FRegWriteM = 1'b0;
        RdW = '0; RegWriteW = 1'b0; FRegWriteW = 1'b0;
    endtask

    // Queue the expectation for the inputs now applied, then advance one clock.
    task automatic vec(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fc,
                       input logic lw, input logic fp, input logic busy, input logic fpn, input logic busyn);
        exp_t e;
        e.tag = tag; e.fa = fa; e.fb = fb; e.fc = fc;
        e.lw = lw; e.fp = fp; e.busy = busy; e.fpn = fpn; e.busyn = busyn;
        e.flushd = PCSrcE;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        vec("reset", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Forwarding
        idle(); RegWriteM = 1; RdM = 5; Rs1E = 5; Rs2E = 6; RdW = 6; RegWriteW = 1; Rs3E = 5;
        vec("fwd_int", 2'b10, 2'b01, 2'b10, 0, 0, 0, 0, 0);
        FpSrcE = 3'b001;
        vec("fwd_class", 2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 0);
        idle(); FpSrcE = 3'b110; RegWriteM = 1; FRegWriteM = 1; RdM = 0; RdW = 0; FRegWriteW = 1;
        vec("fwd_zero", 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0);
        idle(); FpSrcE = 3'b010; Rs1E = 9; Rs2E = 4; Rs3E = 4; RdM = 9; RegWriteM = 1;
        RdW = 4; RegWriteW = 1; FRegWriteW = 1;
        vec("fwd_wb", 2'b10, 2'b01, 2'b01, 0, 0, 0, 0, 0);
        idle(); Rs1E = 12; RdM = 12; RdW = 12; RegWriteM = 1; RegWriteW = 1;
        vec("fwd_prio", 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Load-use
        idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        vec("lw_int", 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        FpSrcD = 3'b010;
        vec("lw_class", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        FpSrcD = 3'b000; RdE = 0; Rs1D = 0; Rs2D = 0;
        vec("lw_x0", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        FpDstE = 1; Rs1D = 1; Rs2D = 1; Rs3D = 0; FpSrcD = 3'b100;
        vec("lw_f0_rs3", 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        RdE = 8; Rs3D = 8; FpSrcD = 3'b000;
        vec("lw_rs3_inv", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // RAW countdown on f3
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 3; FpSrcD = 3'b011; Rs1D = 1; Rs2D = 2;
        vec("raw_issue", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); FpDstD = 1; RdD = 10; FpSrcD = 3'b001; Rs1D = 3;
        for (int i = 1; i <= 4; i++) vec($sformatf("raw_c%0d", i), 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 1);
        vec("raw_c5", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // WAW on f3
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 3;
        vec("waw_issue", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); FpDstD = 1; RdD = 3;
        vec("waw_stall", 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 1);
        idle();
        for (int i = 0; i < 3; i++) vec($sformatf("waw_drain%0d", i), 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        vec("waw_empty", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Back-to-back independent FPU ops: pipelined vs serial
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 5;
        vec("st_s0", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        RdD = 6;
        vec("st_s1", 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        for (int i = 2; i <= 4; i++) vec($sformatf("st_s%0d", i), 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 1);
        vec("st_s5", 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0);
        idle();
        for (int i = 6; i <= 9; i++) vec($sformatf("st_s%0d", i), 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
        vec("st_s10", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Flush beats stall: nothing issues under PCSrcE
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 9;
        vec("fl_a", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 3; FpSrcD = 3'b001; Rs1D = 9; PCSrcE = 1;
        vec("fl_b", 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 1);
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 11; PCSrcE = 1;
        vec("fl_c", 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        idle(); FpDstD = 1; RdD = 3; FpSrcD = 3'b101; Rs1D = 11; Rs3D = 11;
        vec("fl_d", 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        idle();
        vec("fl_e", 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        vec("fl_f", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Reset in the middle of an FPU op
        idle(); FpuOpD = 1; FpDstD = 1; RdD = 3;
        vec("rs_issue", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        idle();
        vec("rs_c4", 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        vec("rs_c3", 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        reset = 1'b1;
        vec("rs_c2", 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        reset = 1'b0;
        FpDstD = 1; RdD = 3; FpSrcD = 3'b001; Rs1D = 3;
        vec("rs_after", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
